// File: rtl/maze_pkg.sv
// Shared types for the BFS maze solver: FSM states, move directions and cell coordinates.
package maze_pkg;

    localparam int COORD_MAX_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SEARCH = 3'd2,
        TRACE  = 3'd3,
        FAIL   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        LEFT  = 2'd1,
        DOWN  = 2'd2,
        RIGHT = 2'd3
    } dir_e;

    typedef struct packed {
        logic [COORD_MAX_W-1:0] x;
        logic [COORD_MAX_W-1:0] y;
    } coord_t;

    // UP<->DOWN and LEFT<->RIGHT differ only in bit 1 of the encoding.
    function automatic dir_e dir_opposite(input dir_e d);
        return dir_e'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/bfs_fifo.sv
// Circular queue of (x,y) cells for the BFS frontier; a push while full is dropped,
// a pop while empty is ignored, clr empties the queue in one cycle.
module bfs_fifo #(
    parameter int Q_DEPTH = 225,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [CW-1:0] push_x,
    input  logic [CW-1:0] push_y,
    output logic [CW-1:0] head_x,
    output logic [CW-1:0] head_y,
    output logic          full,
    output logic          empty
);
    localparam int PW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int NW = $clog2(Q_DEPTH + 1);

    logic [2*CW-1:0] mem [Q_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(Q_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count_q == NW'(Q_DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;
    assign {head_x, head_y} = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      count_d = count_q + NW'(1);
            else if (do_pop && !do_push) count_d = count_q - NW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= {push_x, push_y};
    end

endmodule

// File: rtl/maze_bfs_solver.sv
// BFS maze solver: raster-loads a MAZE_N x MAZE_N wall map, searches (1,1) -> (MAZE_N-2,MAZE_N-2)
// and streams the path goal-first. Define MAZE_BFS_ENDPOINT_CHECK_EN to fail fast on walled endpoints.
module maze_bfs_solver
    import maze_pkg::*;
#(
    parameter int MAZE_N  = 15,
    parameter int CW      = 4,
    parameter int Q_DEPTH = MAZE_N * MAZE_N
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          maze,
    output logic          out_valid,
    output logic          maze_not_valid,
    output logic [CW-1:0] out_x,
    output logic [CW-1:0] out_y
);
    localparam int N2        = MAZE_N * MAZE_N;
    localparam int IW        = $clog2(N2);
    localparam int START_IDX = MAZE_N + 1;
    localparam int GOAL_C    = MAZE_N - 2;
`ifdef MAZE_BFS_ENDPOINT_CHECK_EN
    localparam int GOAL_IDX  = GOAL_C * MAZE_N + GOAL_C;
`endif

    state_e          state_q, state_d;
    logic [IW-1:0]   load_cnt_q, load_cnt_d;
    logic [N2-1:0]   maze_q, maze_d;
    logic [N2-1:0]   visited_q, visited_d;
    logic [2*N2-1:0] parent_q, parent_d;
    logic [CW-1:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [CW-1:0]   trace_x_q, trace_x_d, trace_y_q, trace_y_d;
    dir_e            dir_q, dir_d;
    logic            ovf_q, ovf_d;
    logic            out_valid_q, out_valid_d, out_nv_q, out_nv_d;
    logic [CW-1:0]   out_x_q, out_x_d, out_y_q, out_y_d;

    logic [CW-1:0]   nb_x, nb_y;
    logic [IW-1:0]   nb_idx, trace_idx;
    logic            nb_in_range, nb_take, nb_is_goal;
    dir_e            trace_dir;

    logic            fifo_clr, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]   head_x, head_y;

    function automatic logic [IW-1:0] cell_idx(input logic [CW-1:0] x, input logic [CW-1:0] y);
        return IW'(y) * IW'(MAZE_N) + IW'(x);
    endfunction

    bfs_fifo #(
        .Q_DEPTH (Q_DEPTH),
        .CW      (CW)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (fifo_clr),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .push_x (nb_x),
        .push_y (nb_y),
        .head_x (head_x),
        .head_y (head_y),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Neighbour under examination this cycle; wrapped coordinates are masked by nb_in_range.
    always_comb begin
        nb_x        = cur_x_q;
        nb_y        = cur_y_q;
        nb_in_range = 1'b0;
        unique case (dir_q)
            UP:    begin nb_in_range = (cur_y_q != '0);                nb_y = cur_y_q - CW'(1); end
            LEFT:  begin nb_in_range = (cur_x_q != '0);                nb_x = cur_x_q - CW'(1); end
            DOWN:  begin nb_in_range = (cur_y_q != CW'(MAZE_N - 1));   nb_y = cur_y_q + CW'(1); end
            RIGHT: begin nb_in_range = (cur_x_q != CW'(MAZE_N - 1));   nb_x = cur_x_q + CW'(1); end
        endcase
        nb_idx     = cell_idx(nb_x, nb_y);
        nb_take    = nb_in_range && !maze_q[nb_idx] && !visited_q[nb_idx];
        nb_is_goal = (nb_x == CW'(GOAL_C)) && (nb_y == CW'(GOAL_C));
        trace_idx  = cell_idx(trace_x_q, trace_y_q);
        trace_dir  = dir_e'(parent_q[{trace_idx, 1'b0} +: 2]);
    end

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        maze_d      = maze_q;
        visited_d   = visited_q;
        parent_d    = parent_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        trace_x_d   = trace_x_q;
        trace_y_d   = trace_y_q;
        dir_d       = dir_q;
        ovf_d       = ovf_q;
        fifo_clr    = 1'b0;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        out_valid_d = 1'b0;
        out_nv_d    = 1'b0;
        out_x_d     = '0;
        out_y_d     = '0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    maze_d[0]  = maze;
                    load_cnt_d = IW'(1);
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    maze_d[load_cnt_q] = maze;
                    load_cnt_d         = load_cnt_q + IW'(1);
                    if (load_cnt_q == IW'(N2 - 1)) begin
                        load_cnt_d           = '0;
                        visited_d            = '0;
                        visited_d[START_IDX] = 1'b1;
                        parent_d             = '0;
                        cur_x_d              = CW'(1);
                        cur_y_d              = CW'(1);
                        dir_d                = UP;
                        fifo_clr             = 1'b1;
`ifdef MAZE_BFS_ENDPOINT_CHECK_EN
                        state_d = (maze_q[START_IDX] || maze_q[GOAL_IDX]) ? FAIL : SEARCH;
`else
                        state_d = SEARCH;
`endif
                    end
                end
            end
            SEARCH: begin
                dir_d = dir_e'(dir_q + 2'd1);
                if (nb_take) begin
                    visited_d[nb_idx]                = 1'b1;
                    parent_d[{nb_idx, 1'b0} +: 2]    = dir_opposite(dir_q);
                    // With an empty queue the last neighbour would be popped straight back: use it directly.
                    if (!(dir_q == RIGHT && fifo_empty)) begin
                        fifo_push = 1'b1;
                        if (fifo_full) ovf_d = 1'b1;
                    end
                end
                if (nb_take && nb_is_goal) begin
                    state_d   = TRACE;
                    trace_x_d = nb_x;
                    trace_y_d = nb_y;
                end else if (dir_q == RIGHT) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        cur_x_d  = head_x;
                        cur_y_d  = head_y;
                    end else if (nb_take) begin
                        cur_x_d = nb_x;
                        cur_y_d = nb_y;
                    end else begin
                        state_d = FAIL;
                    end
                end
            end
            TRACE: begin
                out_valid_d = 1'b1;
                out_x_d     = trace_x_q;
                out_y_d     = trace_y_q;
                if (trace_x_q == CW'(1) && trace_y_q == CW'(1)) begin
                    state_d = IDLE;
                end else begin
                    unique case (trace_dir)
                        UP:    trace_y_d = trace_y_q - CW'(1);
                        LEFT:  trace_x_d = trace_x_q - CW'(1);
                        DOWN:  trace_y_d = trace_y_q + CW'(1);
                        RIGHT: trace_x_d = trace_x_q + CW'(1);
                    endcase
                end
            end
            FAIL: begin
                out_valid_d = 1'b1;
                out_nv_d    = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            load_cnt_q  <= '0;
            visited_q   <= '0;
            parent_q    <= '0;
            dir_q       <= UP;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_nv_q    <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            visited_q   <= visited_d;
            parent_q    <= parent_d;
            dir_q       <= dir_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_nv_q    <= out_nv_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
        end
    end

    // Wall map and walk cursors are always rewritten before use, so they carry no reset.
    always_ff @(posedge clk) begin
        maze_q    <= maze_d;
        cur_x_q   <= cur_x_d;
        cur_y_q   <= cur_y_d;
        trace_x_q <= trace_x_d;
        trace_y_q <= trace_y_d;
    end

    assign out_valid      = out_valid_q;
    assign maze_not_valid = out_nv_q;
    assign out_x          = out_x_q;
    assign out_y          = out_y_q;

endmodule

// File: doc/maze_bfs_solver.md
MAZE_BFS_SOLVER -- requirements
Module: maze_bfs_solver

Interface
REQ-001 Parameter MAZE_N, default 15, SHALL set maze side length in cells; odd, 5..15 legal.
REQ-002 Parameter CW, default 4, SHALL set coordinate width; SHALL satisfy 2**CW >= MAZE_N.
REQ-003 Parameter Q_DEPTH, default MAZE_N*MAZE_N, SHALL set BFS queue depth in entries.
REQ-004 Port clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-006 Port in_valid  input  1  SHALL qualify one maze bit per cycle.
REQ-007 Port maze  input  1  SHALL carry the cell value: 1 = wall, 0 = open.
REQ-008 Port out_valid  output  1  SHALL flag a valid result beat.
REQ-009 Port maze_not_valid  output  1  SHALL flag "no path" on the result beat.
REQ-010 Port out_x  output  CW  SHALL carry the path column.
REQ-011 Port out_y  output  CW  SHALL carry the path row.

Function
REQ-012 States SHALL be IDLE, LOAD, SEARCH, TRACE and FAIL.
REQ-013 Load order SHALL be raster: first bit is (row 0, col 0), then columns ascend, then rows.
REQ-014 In IDLE, in_valid SHALL store bit 0 and enter LOAD; LOAD SHALL accept MAZE_N*MAZE_N bits total, in_valid gaps allowed.
REQ-015 On the final bit, the next state SHALL be SEARCH, and visited and parent maps SHALL be cleared.
REQ-016 in_valid outside IDLE/LOAD SHALL be ignored.
REQ-017 Start SHALL be (x=1, y=1); goal SHALL be (MAZE_N-2, MAZE_N-2); start SHALL be pre-marked visited and be the current cell.
REQ-018 SEARCH SHALL examine one neighbour per cycle, in the order up (y-1), left (x-1), down (y+1), right (x+1).
REQ-019 Out-of-range neighbours SHALL be skipped.
REQ-020 An open, unvisited neighbour SHALL be pushed to the FIFO, marked visited, and given a 2-bit parent direction pointing back to the current cell.
REQ-021 After the fourth neighbour, the FIFO head SHALL be popped as the new current cell (true FIFO order, circular pointers with wrap-around).
REQ-022 Pushing the goal SHALL move the block to TRACE next cycle, with the goal as trace cell.
REQ-023 After the fourth neighbour with the FIFO empty, the next state SHALL be FAIL.
REQ-024 In TRACE, out_valid SHALL be 1 and out_x/out_y SHALL carry the trace cell each cycle, goal first, then each parent in turn, ending with the start; the next state SHALL then be IDLE.
REQ-025 Path beats SHALL be contiguous.
REQ-026 In FAIL, exactly one beat SHALL be out_valid=1, maze_not_valid=1, out_x=out_y=0; the next state SHALL then be IDLE.
REQ-027 Outputs SHALL be registered; outside result beats, out_valid, maze_not_valid, out_x and out_y SHALL be 0.
REQ-028 A push with the FIFO full SHALL be dropped and the sticky debug flag ovf_q set; with the default Q_DEPTH this SHALL be unreachable.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE and clear the load counter, FIFO pointers, visited map, parent map and all outputs; the maze map is don't-care.
REQ-030 Reset mid-LOAD/SEARCH/TRACE SHALL abandon the operation; the next result SHALL come only after a full new load.

Configuration
REQ-031 With MAZE_BFS_ENDPOINT_CHECK_EN defined: if the start or goal cell is a wall at end of load, SEARCH SHALL be skipped and FAIL entered directly.
REQ-032 Without MAZE_BFS_ENDPOINT_CHECK_EN: a walled goal SHALL be found unreachable by normal search, and a walled start cell SHALL be ignored.

Structure
REQ-033 Package maze_pkg SHALL hold the state enum, the direction enum (UP=0, LEFT=1, DOWN=2, RIGHT=3) and a coordinate struct {x,y} typedef.
REQ-034 The BFS queue SHALL be the sub-module bfs_fifo (parameters Q_DEPTH and CW; push/pop/full/empty; holds coordinate pairs).

Verification
REQ-035 MAZE_N=5, border walls, interior open -> beats (3,3),(2,3),(1,3),(1,2),(1,1), then out_valid=0.
REQ-036 MAZE_N=15, full wall row at y=7 -> single beat out_valid=1, maze_not_valid=1, out_x=out_y=0.
REQ-037 MAZE_N=15, one-cell-wide serpentine corridor -> beat count equals corridor length plus 1, first beat (13,13), last beat (1,1).
REQ-038 rst_n low during SEARCH, then a new open 5x5 load -> no stale beats; path of REQ-035 reproduced.
REQ-039 MAZE_N=5 with goal (3,3) walled, macro defined -> FAIL beat within 2 cycles of the last load bit; undefined -> FAIL beat after search exhausts.
REQ-040 in_valid held high through SEARCH and TRACE -> extra bits ignored, path of REQ-035 unchanged.
